// File: rtl/gshare_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : gshare_branch_predictor
// Purpose  : Dual-slot fetch predictor (slot 0 = pc, slot 1 = pc+4) built
//            from a gshare PHT, a typed/tagged BTB and a speculative RAS
//            backed by a committed RAS used for misprediction repair.
// Ports    : clk, rst              - clock, synchronous active-high reset
//            if_stall, pc          - fetch hold and slot-0 fetch PC
//            pred_taken_0/1,
//            pred_target_0/1       - per-slot prediction (target 0 if not taken)
//            pred_ghr              - speculative global history for the packet
//            ex_*                  - EX-stage training / repair interface
// Revision : 1.0 - initial release
// ============================================================================
module gshare_branch_predictor #(
    parameter int PHT_IDX_W = 10,
    parameter int BTB_IDX_W = 8,
    parameter int GHR_W     = 8,
    parameter int RAS_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_stall,
    input  logic [31:0]      pc,
    output logic             pred_taken_0,
    output logic [31:0]      pred_target_0,
    output logic             pred_taken_1,
    output logic [31:0]      pred_target_1,
    output logic [GHR_W-1:0] pred_ghr,
    input  logic             ex_valid,
    input  logic             ex_stall,
    input  logic [31:0]      ex_pc,
    input  logic             ex_is_br,
    input  logic             ex_is_call,
    input  logic             ex_is_ret,
    input  logic             ex_act_taken,
    input  logic [31:0]      ex_act_target,
    input  logic [GHR_W-1:0] ex_ghr,
    input  logic             ex_mispredict
);

    localparam int c_PHT_N  = 1 << PHT_IDX_W;
    localparam int c_BTB_N  = 1 << BTB_IDX_W;
    localparam int c_TAG_W  = 30 - BTB_IDX_W;
    localparam int c_RAS_PW = $clog2(RAS_DEPTH);
    localparam int c_RAS_CW = c_RAS_PW + 1;

    localparam logic [1:0] c_T_COND = 2'd0;
    localparam logic [1:0] c_T_JMP  = 2'd1;
    localparam logic [1:0] c_T_CALL = 2'd2;
    localparam logic [1:0] c_T_RET  = 2'd3;

    localparam logic [c_RAS_PW-1:0] c_PTR_ONE  = c_RAS_PW'(1);
    localparam logic [c_RAS_CW-1:0] c_CNT_ONE  = c_RAS_CW'(1);
    localparam logic [c_RAS_CW-1:0] c_CNT_FULL = c_RAS_CW'(RAS_DEPTH);

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [1:0]          r_pht       [c_PHT_N];
    logic                r_btb_valid [c_BTB_N];
    logic [c_TAG_W-1:0]  r_btb_tag   [c_BTB_N];
    logic [31:0]         r_btb_tgt   [c_BTB_N];
    logic [1:0]          r_btb_type  [c_BTB_N];
    logic [GHR_W-1:0]    r_ghr;

    // RAS pointer addresses the next free slot; top is at pointer-1.
    logic [31:0]         r_sras [RAS_DEPTH];
    logic [c_RAS_PW-1:0] r_sras_ptr;
    logic [c_RAS_CW-1:0] r_sras_cnt;
    logic [31:0]         r_cras [RAS_DEPTH];
    logic [c_RAS_PW-1:0] r_cras_ptr;
    logic [c_RAS_CW-1:0] r_cras_cnt;

    // ------------------------------------------------------------------
    // Lookup, one copy per slot
    // ------------------------------------------------------------------
    logic [1:0][31:0]          w_pc;
    logic [1:0][PHT_IDX_W-1:0] w_pht_idx;
    logic [1:0][BTB_IDX_W-1:0] w_btb_idx;
    logic [1:0]                w_hit;
    logic [1:0][1:0]           w_type;
    logic [1:0]                w_cond_hit;
    logic [1:0]                w_raw_taken;
    logic [1:0][31:0]          w_raw_tgt;
    logic [31:0]               w_sras_top;

    assign w_sras_top = r_sras[r_sras_ptr - c_PTR_ONE];

    for (genvar k = 0; k < 2; k++) begin : g_slot
        localparam logic [31:0] c_OFS = 32'(4 * k);
        assign w_pc[k]        = pc + c_OFS;
        assign w_pht_idx[k]   = w_pc[k][PHT_IDX_W+1:2] ^ PHT_IDX_W'(r_ghr);
        assign w_btb_idx[k]   = w_pc[k][BTB_IDX_W+1:2];
        assign w_hit[k]       = r_btb_valid[w_btb_idx[k]] &&
                                (r_btb_tag[w_btb_idx[k]] == w_pc[k][31:BTB_IDX_W+2]);
        assign w_type[k]      = r_btb_type[w_btb_idx[k]];
        assign w_cond_hit[k]  = w_hit[k] && (w_type[k] == c_T_COND);
        assign w_raw_taken[k] = w_hit[k] &&
                                ((w_type[k] != c_T_COND) || r_pht[w_pht_idx[k]][1]);
        // An empty RAS falls back to whatever the BTB learned for the return.
        assign w_raw_tgt[k]   = ((w_type[k] == c_T_RET) && (r_sras_cnt != '0)) ?
                                w_sras_top : r_btb_tgt[w_btb_idx[k]];
    end

    // Slot 1 is never reached when slot 0 redirects fetch.
    assign pred_taken_0  = w_raw_taken[0];
    assign pred_taken_1  = w_raw_taken[1] & ~w_raw_taken[0];
    assign pred_target_0 = pred_taken_0 ? w_raw_tgt[0] : '0;
    assign pred_target_1 = pred_taken_1 ? w_raw_tgt[1] : '0;
    assign pred_ghr      = r_ghr;

    // ------------------------------------------------------------------
    // Speculative update controls
    // ------------------------------------------------------------------
    logic [GHR_W-1:0] w_ghr_spec;
    logic [1:0]       w_sel_type;
    logic             w_spec_push;
    logic             w_spec_pop;
    logic [31:0]      w_spec_ret_addr;

    always_comb begin
        w_ghr_spec = r_ghr;
        if (w_cond_hit[0]) begin
            w_ghr_spec = (r_ghr << 1) | GHR_W'(w_raw_taken[0]);
        end else if (w_cond_hit[1] && !w_raw_taken[0]) begin
            w_ghr_spec = (r_ghr << 1) | GHR_W'(w_raw_taken[1]);
        end
    end

    assign w_sel_type      = pred_taken_0 ? w_type[0] : w_type[1];
    assign w_spec_push     = (pred_taken_0 | pred_taken_1) && (w_sel_type == c_T_CALL);
    assign w_spec_pop      = (pred_taken_0 | pred_taken_1) && (w_sel_type == c_T_RET);
    assign w_spec_ret_addr = (pred_taken_0 ? w_pc[0] : w_pc[1]) + 32'd4;

    // ------------------------------------------------------------------
    // Training / repair controls
    // ------------------------------------------------------------------
    logic                 w_train;
    logic                 w_repair;
    logic [PHT_IDX_W-1:0] w_ex_pht_idx;
    logic [BTB_IDX_W-1:0] w_ex_btb_idx;
    logic [1:0]           w_pht_cur;
    logic [1:0]           w_pht_upd;
    logic [1:0]           w_ex_type;
    logic [GHR_W-1:0]     w_ghr_repair;

    assign w_train      = ex_valid & ~ex_stall;
    assign w_repair     = w_train & ex_mispredict;
    assign w_ex_pht_idx = ex_pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(ex_ghr);
    assign w_ex_btb_idx = ex_pc[BTB_IDX_W+1:2];
    assign w_pht_cur    = r_pht[w_ex_pht_idx];
    assign w_pht_upd    = ex_act_taken ? ((w_pht_cur == 2'd3) ? 2'd3 : w_pht_cur + 2'd1)
                                       : ((w_pht_cur == 2'd0) ? 2'd0 : w_pht_cur - 2'd1);
    assign w_ex_type    = ex_is_ret  ? c_T_RET  :
                          ex_is_call ? c_T_CALL :
                          ex_is_br   ? c_T_COND : c_T_JMP;
    assign w_ghr_repair = ex_is_br ? ((ex_ghr << 1) | GHR_W'(ex_act_taken)) : ex_ghr;

    // Committed RAS after this cycle's EX effect; also the repair image.
    logic [31:0]         w_cras_n [RAS_DEPTH];
    logic [c_RAS_PW-1:0] w_cras_ptr_n;
    logic [c_RAS_CW-1:0] w_cras_cnt_n;

    always_comb begin
        w_cras_n     = r_cras;
        w_cras_ptr_n = r_cras_ptr;
        w_cras_cnt_n = r_cras_cnt;
        if (w_train) begin
            if (ex_is_call) begin
                w_cras_n[r_cras_ptr] = ex_pc + 32'd4;
                w_cras_ptr_n         = r_cras_ptr + c_PTR_ONE;
                if (r_cras_cnt != c_CNT_FULL) begin
                    w_cras_cnt_n = r_cras_cnt + c_CNT_ONE;
                end
            end else if (ex_is_ret && (r_cras_cnt != '0)) begin
                w_cras_ptr_n = r_cras_ptr - c_PTR_ONE;
                w_cras_cnt_n = r_cras_cnt - c_CNT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // State update
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_PHT_N; i++) r_pht[i] <= 2'b01;
            for (int i = 0; i < c_BTB_N; i++) r_btb_valid[i] <= 1'b0;
            r_ghr      <= '0;
            r_sras_ptr <= '0;
            r_sras_cnt <= '0;
            r_cras_ptr <= '0;
            r_cras_cnt <= '0;
        end else begin
            if (w_train) begin
                if (ex_is_br) begin
                    r_pht[w_ex_pht_idx] <= w_pht_upd;
                end
                if (ex_act_taken) begin
                    r_btb_valid[w_ex_btb_idx] <= 1'b1;
                    r_btb_tag[w_ex_btb_idx]   <= ex_pc[31:BTB_IDX_W+2];
                    r_btb_tgt[w_ex_btb_idx]   <= ex_act_target;
                    r_btb_type[w_ex_btb_idx]  <= w_ex_type;
                end
            end

            r_cras     <= w_cras_n;
            r_cras_ptr <= w_cras_ptr_n;
            r_cras_cnt <= w_cras_cnt_n;

            if (w_repair) begin
                r_ghr      <= w_ghr_repair;
                r_sras     <= w_cras_n;
                r_sras_ptr <= w_cras_ptr_n;
                r_sras_cnt <= w_cras_cnt_n;
            end else if (!if_stall) begin
                r_ghr <= w_ghr_spec;
                if (w_spec_push) begin
                    r_sras[r_sras_ptr] <= w_spec_ret_addr;
                    r_sras_ptr         <= r_sras_ptr + c_PTR_ONE;
                    if (r_sras_cnt != c_CNT_FULL) begin
                        r_sras_cnt <= r_sras_cnt + c_CNT_ONE;
                    end
                end else if (w_spec_pop && (r_sras_cnt != '0)) begin
                    r_sras_ptr <= r_sras_ptr - c_PTR_ONE;
                    r_sras_cnt <= r_sras_cnt - c_CNT_ONE;
                end
            end
        end
    end

    // Byte-offset bits of instruction addresses carry no information.
    logic w_unused_bits;
    assign w_unused_bits = ^{pc[1:0], ex_pc[1:0], w_pc[0][1:0], w_pc[1][1:0]};

endmodule
`default_nettype wire

// File: tb/tb_gshare_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : tb_gshare_branch_predictor
// Purpose  : Directed self-checking bench for gshare_branch_predictor using a
//            table of lookup vectors plus hand-written multi-cycle sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gshare_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_stall;
    logic [31:0] pc;
    logic        pred_taken_0, pred_taken_1;
    logic [31:0] pred_target_0, pred_target_1;
    logic [7:0]  pred_ghr;
    logic        ex_valid, ex_stall, ex_is_br, ex_is_call, ex_is_ret;
    logic        ex_act_taken, ex_mispredict;
    logic [31:0] ex_pc, ex_act_target;
    logic [7:0]  ex_ghr;

    int total = 0;
    int bad   = 0;

    gshare_branch_predictor dut (
        .clk          (clk),
        .rst          (rst),
        .if_stall     (if_stall),
        .pc           (pc),
        .pred_taken_0 (pred_taken_0),
        .pred_target_0(pred_target_0),
        .pred_taken_1 (pred_taken_1),
        .pred_target_1(pred_target_1),
        .pred_ghr     (pred_ghr),
        .ex_valid     (ex_valid),
        .ex_stall     (ex_stall),
        .ex_pc        (ex_pc),
        .ex_is_br     (ex_is_br),
        .ex_is_call   (ex_is_call),
        .ex_is_ret    (ex_is_ret),
        .ex_act_taken (ex_act_taken),
        .ex_act_target(ex_act_target),
        .ex_ghr       (ex_ghr),
        .ex_mispredict(ex_mispredict)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  ghr;
        logic [31:0] pc;
        logic        t0;
        logic [31:0] g0;
        logic        t1;
        logic [31:0] g1;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_clear();
        ex_valid = 0; ex_stall = 0; ex_pc = 0; ex_is_br = 0; ex_is_call = 0;
        ex_is_ret = 0; ex_act_taken = 0; ex_act_target = 0; ex_ghr = 0;
        ex_mispredict = 0;
    endtask

    task automatic train(input logic [31:0] p, input logic br, input logic call,
                         input logic ret, input logic tk, input logic [31:0] tgt,
                         input logic [7:0] g, input logic mis, input logic stl);
        ex_valid = 1; ex_stall = stl; ex_pc = p; ex_is_br = br; ex_is_call = call;
        ex_is_ret = ret; ex_act_taken = tk; ex_act_target = tgt; ex_ghr = g;
        ex_mispredict = mis;
        cyc();
        ex_clear();
    endtask

    // Repair with a non-branch forces the GHR to an exact value.
    task automatic set_ghr(input logic [7:0] g);
        train(32'h0, 0, 0, 0, 0, 32'h0, g, 1, 0);
    endtask

    // Check slot 0 at the falling edge; caller is just past a rising edge.
    task automatic look(input string nm, input logic [31:0] p,
                        input logic t0, input logic [31:0] g0);
        pc = p;
        @(negedge clk);
        chk({nm, "_t0"}, {31'b0, pred_taken_0}, {31'b0, t0});
        chk({nm, "_g0"}, pred_target_0, g0);
    endtask

    // Same check, then let the fetch update speculative state on the next edge.
    task automatic look_go(input string nm, input logic [31:0] p,
                           input logic t0, input logic [31:0] g0);
        look(nm, p, t0, g0);
        if_stall = 0;
        cyc();
        if_stall = 1;
    endtask

    initial begin
        tbl[0] = '{ghr: 8'h00, pc: 32'h100, t0: 1, g0: 32'h200, t1: 0, g1: 32'h0};
        tbl[1] = '{ghr: 8'h01, pc: 32'h100, t0: 0, g0: 32'h0,   t1: 0, g1: 32'h0};
        tbl[2] = '{ghr: 8'h00, pc: 32'h300, t0: 1, g0: 32'h500, t1: 0, g1: 32'h0};
        tbl[3] = '{ghr: 8'h00, pc: 32'h2FC, t0: 0, g0: 32'h0,   t1: 1, g1: 32'h500};
        tbl[4] = '{ghr: 8'h00, pc: 32'h304, t0: 1, g0: 32'h600, t1: 0, g1: 32'h0};
        tbl[5] = '{ghr: 8'h00, pc: 32'h500, t0: 0, g0: 32'h0,   t1: 0, g1: 32'h0};

        rst = 1; if_stall = 1; pc = 0;
        ex_clear();
        repeat (3) @(posedge clk);
        #1;
        rst = 0;

        // Reset state
        pc = 32'h100;
        @(negedge clk);
        chk("rst_t0", {31'b0, pred_taken_0}, 32'd0);
        chk("rst_t1", {31'b0, pred_taken_1}, 32'd0);
        chk("rst_g0", pred_target_0, 32'd0);
        chk("rst_g1", pred_target_1, 32'd0);
        chk("rst_ghr", {24'b0, pred_ghr}, 32'd0);
        cyc();

        // COND at 0x100 trained taken twice; JMPs at 0x300 and 0x304
        train(32'h100, 1, 0, 0, 1, 32'h200, 8'h00, 0, 0);
        train(32'h100, 1, 0, 0, 1, 32'h200, 8'h00, 0, 0);
        train(32'h300, 0, 0, 0, 1, 32'h500, 8'h00, 0, 0);
        train(32'h304, 0, 0, 0, 1, 32'h600, 8'h00, 0, 0);

        for (int i = 0; i < 6; i++) begin
            set_ghr(tbl[i].ghr);
            pc = tbl[i].pc;
            @(negedge clk);
            chk($sformatf("vec%0d_t0", i), {31'b0, pred_taken_0}, {31'b0, tbl[i].t0});
            chk($sformatf("vec%0d_g0", i), pred_target_0, tbl[i].g0);
            chk($sformatf("vec%0d_t1", i), {31'b0, pred_taken_1}, {31'b0, tbl[i].t1});
            chk($sformatf("vec%0d_g1", i), pred_target_1, tbl[i].g1);
            chk($sformatf("vec%0d_ghr", i), {24'b0, pred_ghr}, {24'b0, tbl[i].ghr});
            cyc();
        end

        // CALL/RET: committed RAS ends up holding only 0x484
        train(32'h400, 0, 1, 0, 1, 32'h800, 8'h00, 0, 0);
        train(32'h900, 0, 0, 1, 1, 32'h9F0, 8'h00, 0, 0);
        train(32'h480, 0, 1, 0, 1, 32'h800, 8'h00, 0, 0);
        look("ret_empty", 32'h900, 1, 32'h9F0);
        look_go("call0", 32'h400, 1, 32'h800);
        look_go("ret_top", 32'h900, 1, 32'h404);
        look("ret_empty2", 32'h900, 1, 32'h9F0);

        // Overflow: 0x484 pushed first, then eight 0x404 pushes overwrite it
        look_go("call_480", 32'h480, 1, 32'h800);
        for (int i = 0; i < 8; i++) look_go($sformatf("ovf_call%0d", i), 32'h400, 1, 32'h800);
        for (int i = 0; i < 8; i++) look_go($sformatf("ovf_ret%0d", i), 32'h900, 1, 32'h404);
        look("ovf_empty", 32'h900, 1, 32'h9F0);

        // Repair: GHR restore and speculative RAS replaced by committed copy
        train(32'h140, 1, 0, 0, 1, 32'h260, 8'h00, 0, 0);
        train(32'h140, 1, 0, 0, 1, 32'h260, 8'h00, 0, 0);
        set_ghr(8'hA5);
        look_go("spec_call", 32'h400, 1, 32'h800);
        chk("ghr_a5", {24'b0, pred_ghr}, 32'hA5);
        cyc();
        pc = 32'h140; if_stall = 0;
        train(32'h600, 1, 0, 0, 1, 32'h700, 8'h12, 1, 0);
        if_stall = 1;
        look("rep_ras", 32'h900, 1, 32'h484);
        chk("rep_ghr", {24'b0, pred_ghr}, 32'h25);
        cyc();
        train(32'h740, 0, 1, 0, 1, 32'h800, 8'h25, 1, 0);
        look_go("rep_call0", 32'h900, 1, 32'h744);
        look_go("rep_call1", 32'h900, 1, 32'h484);
        look("rep_call2", 32'h900, 1, 32'h9F0);
        chk("rep_call_ghr", {24'b0, pred_ghr}, 32'h25);
        cyc();

        // ex_stall blocks training
        set_ghr(8'h00);
        look("stl_pre", 32'h140, 1, 32'h260);
        cyc();
        train(32'h140, 1, 0, 0, 0, 32'h0,   8'h00, 0, 1);
        train(32'h140, 1, 0, 0, 0, 32'h0,   8'h00, 0, 1);
        train(32'h180, 1, 0, 0, 1, 32'h280, 8'h00, 0, 1);
        look("stl_pht", 32'h140, 1, 32'h260);
        cyc();
        look("stl_btb", 32'h180, 0, 32'h0);
        cyc();

        // Mid-stream reset overrides a same-cycle training
        rst = 1;
        train(32'h180, 1, 0, 0, 1, 32'h280, 8'h00, 0, 0);
        rst = 0;
        look("mrst_140", 32'h140, 0, 32'h0);
        chk("mrst_ghr", {24'b0, pred_ghr}, 32'h0);
        cyc();
        look("mrst_180", 32'h180, 0, 32'h0);
        cyc();
        look("mrst_300", 32'h300, 0, 32'h0);
        cyc();

        // Positive control: the same training without stall or reset takes effect
        train(32'h180, 1, 0, 0, 1, 32'h280, 8'h00, 0, 0);
        look("post_180", 32'h180, 1, 32'h280);
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gshare_branch_predictor.md
Name: gshare_branch_predictor

Overview:
Dual-slot next-generation fetch predictor for the IFU. Each cycle it predicts two sequential instructions (pc, pc+4) in the same cycle. It combines:
- a gshare PHT, indexed by PC XOR global history;
- a typed, tagged BTB;
- a speculative return address stack (RAS) with a committed shadow copy.

Training and repair come from the EX stage.

Parameters:
- PHT_IDX_W, 10, log2 of PHT entries (2-bit counters).
- BTB_IDX_W, 8, log2 of BTB entries; tag = pc[31:BTB_IDX_W+2].
- GHR_W, 8, global history length; legal range 1..PHT_IDX_W.
- RAS_DEPTH, 8, RAS entries; power of two, at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- if_stall  in  1  fetch held; blocks speculative GHR/RAS updates
- pc  in  32  fetch PC of slot 0; slot 1 = pc+4 (computed internally)
- pred_taken_0  out  1  slot 0 predicted taken
- pred_target_0  out  32  slot 0 target
- pred_taken_1  out  1  slot 1 predicted taken
- pred_target_1  out  32  slot 1 target
- pred_ghr  out  GHR_W  current speculative GHR; carried down the pipe with the fetch packet
- ex_valid  in  1  EX-stage control-flow instruction present
- ex_stall  in  1  EX held; no training
- ex_pc  in  32  PC of the EX instruction
- ex_is_br  in  1  conditional branch
- ex_is_call  in  1  call
- ex_is_ret  in  1  return
- ex_act_taken  in  1  resolved direction (1 for unconditional)
- ex_act_target  in  32  resolved target
- ex_ghr  in  GHR_W  pred_ghr snapshot carried with this instruction
- ex_mispredict  in  1  direction or target mispredicted; triggers repair

Behaviour:
Lookup (combinational, zero latency; reads array contents from before this cycle's clock edge):
- PHT index_k = pc_k[PHT_IDX_W+1:2] XOR zero-extended GHR.
- BTB entry fields: valid, tag, target[31:0], type[1:0] (0=COND, 1=JMP, 2=CALL, 3=RET).
- hit_k = valid & tag match. Each slot compares against its own pc_k tag.
- taken_k = hit_k & (type != COND | pht[index_k][1]).
- Target for a RET: RAS top; if the RAS is empty, the BTB target.
- Target for any other type: the BTB target.
- pred_taken_1 is forced to 0 when pred_taken_0 = 1.
- pred_target_k = 0 whenever pred_taken_k = 0.

Speculative update (clock edge with ~if_stall and not repairing):
- GHR shifts left by at most one bit per cycle:
  - if slot 0 hit COND, shift in taken_0;
  - else if slot 1 hit COND and taken_0 = 0, shift in taken_1;
  - else no change.
- RAS acts on the predicted-taken slot only: CALL pushes pc_k+4; RET pops.
- RAS push when full overwrites the oldest entry (circular pointer; count saturates at RAS_DEPTH).
- RAS pop when empty: no change.

Training (clock edge with ex_valid & ~ex_stall):
- If ex_is_br: saturating 2-bit counter at ex_pc[PHT_IDX_W+1:2] XOR ex_ghr. Increment if taken, decrement if not; saturate at 3 and 0.
- If ex_act_taken: write BTB at ex_pc index with valid=1, tag, target=ex_act_target.
  - type priority: RET > CALL > COND > JMP.
- Not-taken conditionals do not touch the BTB.
- Committed RAS applies ex_is_call (push ex_pc+4) or ex_is_ret (pop), with the same full/empty rules as the speculative RAS.

Repair (ex_valid & ex_mispredict & ~ex_stall):
- GHR <= ex_is_br ? {ex_ghr[GHR_W-2:0], ex_act_taken} : ex_ghr.
- Speculative RAS (entries, pointer, count) <= committed RAS including this cycle's call/ret effect.
- Repair has priority over the same-cycle speculative update, which is dropped. Training still occurs.

Reset:
- All BTB valid bits = 0; all PHT counters = 2'b01; GHR = 0.
- Both RAS copies: count = 0, pointer = 0.
- Outputs after reset: pred_taken_* = 0, pred_target_* = 0, pred_ghr = 0.
- rst asserted mid-operation overrides all update and repair activity that cycle.

Test Plan:
1. Reset, then any pc -> pred_taken_0/1 = 0, targets = 0, pred_ghr = 0.
2. Train COND at 0x100 taken twice with ex_ghr = 0 (target 0x200); then pc = 0x100 with GHR = 0 -> pred_taken_0 = 1, pred_target_0 = 0x200. Same pc with GHR = 0x01 (different PHT index, counter 01) -> pred_taken_0 = 0.
3. BTB hits at both 0x300 (JMP) and 0x304 -> pred_taken_0 = 1, pred_taken_1 = 0. Slot-1-only hit at pc = 0x2FC -> pred_taken_1 = 1 with the 0x300 target.
4. CALL trained at 0x400 (target 0x800) and RET at 0x900; fetch 0x400 then 0x900 -> RET target = 0x404. Perform RAS_DEPTH+1 calls without returns -> oldest overwritten; the next RET predicts the latest pc+4.
5. Speculative GHR = 0xA5 with pending mispredict (ex_is_br = 1, ex_ghr = 0x12, ex_act_taken = 1) asserted alongside an if_stall-free COND hit -> next pred_ghr = 0x25. Speculative RAS equals the committed copy.
6. ex_stall = 1 during a taken branch -> PHT/BTB unchanged. rst pulsed mid-stream -> all predictions return to not-taken.
